arcade_input_mapper: RTL and testbench
======================================

Name: arcade_input_mapper

Overview:
- Parametrised successor to the fixed PS/2-to-button decode in the arcade emu tops.
- Turns hps_io ps2_key events into per-player button state through a run-time loadable keymap table, then merges it with the MiSTer joystick words.
- Applies screen-orientation rotation, a coin-pulse stretcher and per-button autofire.
- Outputs are registered, active-high control vectors that feed the core's input registers.

Parameters:
- PLAYERS, 2, number of player vectors (1..4).
- BUTTONS, 4, fire buttons per player (1..8).
- MAP_DEPTH, 32, keymap entries (power of 2, 4..64).
- COIN_HOLD, 6000, minimum coin-high time in ce ticks (16-bit).
- AF_DIV, 3000, autofire half-period in ce ticks (16-bit).

Ports:
- clk_sys in 1: system clock.
- reset_n in 1: synchronous, active-low reset.
- ce in 1: tick enable for the coin and autofire timers.
- ps2_key in 11: [10] toggle strobe, [9] pressed, [8:0] extended scancode.
- joy_in in 16*PLAYERS: MiSTer joystick words; [0]R [1]L [2]D [3]U, fire from bit 4.
- map_wr in 1: keymap write strobe.
- map_addr in log2(MAP_DEPTH): keymap entry index.
- map_data in 16: [15] valid, [14:13] player, [12:9] function, [8:0] scancode.
- rotate in 2: 0 none, 1 CW, 2 CCW, 3 180.
- af_en in BUTTONS*PLAYERS: autofire enable per button.
- btn_out out (BUTTONS+6)*PLAYERS: per player [0]R [1]L [2]D [3]U [4+:BUTTONS] fire, [BUTTONS+4] start, [BUTTONS+5] coin.
- drop_cnt out 8: saturating count of dropped key events.
- busy out 1: keymap scan in progress.

Behaviour:
- Function codes: 0 R, 1 L, 2 D, 3 U, 4..4+BUTTONS-1 fire, 12 start, 13 coin, others ignored. Player field values >= PLAYERS are ignored.
- Reset (reset_n low at an edge):
  - key state, btn_out, drop_cnt, busy, pending, timers all cleared to 0;
  - old_toggle loaded from ps2_key[10], so the first post-reset level is not an event;
  - keymap RAM contents are preserved.
- Event detect: ps2_key[10] != old_toggle at edge 0 latches {pressed, code} into a 1-deep pending register; old_toggle updates every cycle.
- Pending full when a new event arrives: new event discarded, drop_cnt += 1, saturating at 255.
- FSM IDLE -> SCAN when pending is valid:
  - SCAN examines entry i at edge 2+i and writes key_state[player][func] <= pressed on a valid scancode match;
  - every matching entry applies, so one key may drive several functions or players;
  - SCAN -> IDLE after entry MAP_DEPTH-1; pending is released on the same edge.
  - busy = (state == SCAN).
- Worst-case press-to-btn_out latency is MAP_DEPTH+3 cycles.
- Map writes are accepted in any state; a scan sees entry content as of the cycle it is examined.
- Rewriting an entry does not release key state; a held key stays set until its release event or reset.
- Merge, per player: raw = key_state | {joy start/fire bits remapped to function order}. Joystick bit 4+j maps to fire j; joy bit 4+BUTTONS maps to start.
- Rotation on directions, as (U,D,L,R) <=:
  - 0: (U,D,L,R)
  - 1 CW: (L,R,D,U)
  - 2 CCW: (R,L,U,D)
  - 3 180: (D,U,R,L)
- Coin stretcher, per player:
  - raw coin rising edge loads counter with COIN_HOLD;
  - counter decrements on ce while nonzero;
  - output coin = raw | (counter != 0);
  - a re-edge while counting reloads the counter.
- Autofire, per fire button with af_en set and raw held:
  - output toggles every AF_DIV ce ticks, starting high on the press edge;
  - on release the output is 0 immediately and the phase resets;
  - with af_en clear the output equals raw.
- btn_out is registered one cycle after the merge/rotate/timer logic.
- Simultaneous press and release events in consecutive cycles: the first is scanned, the second pends, any third is dropped.

Test Plan:
1. Default map: entry 0 = {1, P0, U, 0x075}, entry 1 = {1, P1, fire0, 0x01C}. Send press 0x075 -> btn_out P0[3]=1 within MAP_DEPTH+3 cycles; send release -> P0[3]=0.
2. rotate=1 with joy_in P0 = 0x0002 (L) -> P0[3] (U)=1, all other directions 0. Repeat for rotate 2 and 3 against the table.
3. Three toggles on consecutive cycles with MAP_DEPTH=32 -> first two applied in order, drop_cnt=1. Scenario repeated 300 times -> drop_cnt=255.
4. Coin key pressed for 1 cycle, COIN_HOLD=4, ce every cycle -> coin high exactly 5 cycles after the registered edge. Second press at count 2 -> hold extends to 4 more ticks.
5. af_en P0 fire0=1, AF_DIV=2, fire held 10 ce ticks -> pattern 1,1,0,0,1,1,0,0,1,1. Release -> 0 next cycle.
6. Assert reset_n=0 mid-SCAN with key held -> btn_out=0, busy=0, and no event from the current toggle level. Keymap entry 0 still matches after reset.

Source files
------------

// File: rtl/arcade_input_mapper.sv
// Maps PS/2 key events through a loadable keymap and merges them with joystick
// words into registered per-player button vectors (rotation, coin stretch, autofire).
module arcade_input_mapper #(
    parameter int          PLAYERS   = 2,
    parameter int          BUTTONS   = 4,
    parameter int          MAP_DEPTH = 32,
    parameter logic [15:0] COIN_HOLD = 16'd6000,
    parameter logic [15:0] AF_DIV    = 16'd3000
) (
    input  logic                           clk_sys,
    input  logic                           reset_n,
    input  logic                           ce,
    input  logic [10:0]                    ps2_key,
    input  logic [16*PLAYERS-1:0]          joy_in,
    input  logic                           map_wr,
    input  logic [$clog2(MAP_DEPTH)-1:0]   map_addr,
    input  logic [15:0]                    map_data,
    input  logic [1:0]                     rotate,
    input  logic [BUTTONS*PLAYERS-1:0]     af_en,
    output logic [(BUTTONS+6)*PLAYERS-1:0] btn_out,
    output logic [7:0]                     drop_cnt,
    output logic                           busy
);
    localparam int         NB       = BUTTONS + 6;
    localparam int         AW       = $clog2(MAP_DEPTH);
    localparam int         FBW      = $clog2(NB);
    localparam logic [3:0] FIRE_END = 4'(4 + BUTTONS);

    typedef enum logic {IDLE, SCAN} state_t;

    logic [15:0] map_mem [MAP_DEPTH];

    state_t        state_q;
    logic [AW-1:0] idx_q;
    logic          old_tog_q;
    logic          pend_vld_q;
    logic          pend_press_q;
    logic [8:0]    pend_code_q;
    logic          cur_press_q;
    logic [8:0]    cur_code_q;
    logic [7:0]    drop_q;

    logic          evt;
    logic          take;
    logic [15:0]   ent;
    logic          func_ok;
    logic [FBW-1:0] func_bit;
    logic          scan_hit;

    assign evt  = ps2_key[10] != old_tog_q;
    assign take = (state_q == IDLE) && pend_vld_q;

    always_ff @(posedge clk_sys) begin
        if (map_wr) begin
            map_mem[map_addr] <= map_data;
        end
    end

    // Asynchronous read: the scan sees each entry as it stands in the cycle it is examined.
    assign ent = map_mem[idx_q];

    always_comb begin
        func_ok  = 1'b0;
        func_bit = '0;
        if (ent[12:9] < FIRE_END) begin
            func_ok  = 1'b1;
            func_bit = FBW'(ent[12:9]);
        end else if (ent[12:9] == 4'd12) begin
            func_ok  = 1'b1;
            func_bit = FBW'(BUTTONS + 4);
        end else if (ent[12:9] == 4'd13) begin
            func_ok  = 1'b1;
            func_bit = FBW'(BUTTONS + 5);
        end
    end

    assign scan_hit = (state_q == SCAN) && ent[15] && (ent[8:0] == cur_code_q) && func_ok;

    // The scanned event moves out of the pending slot, so one more event can queue behind it.
    always_ff @(posedge clk_sys) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            idx_q        <= '0;
            old_tog_q    <= ps2_key[10];
            pend_vld_q   <= 1'b0;
            pend_press_q <= 1'b0;
            pend_code_q  <= '0;
            cur_press_q  <= 1'b0;
            cur_code_q   <= '0;
            drop_q       <= '0;
        end else begin
            old_tog_q <= ps2_key[10];
            case (state_q)
                IDLE: begin
                    if (pend_vld_q) begin
                        state_q     <= SCAN;
                        idx_q       <= '0;
                        cur_press_q <= pend_press_q;
                        cur_code_q  <= pend_code_q;
                    end
                end
                SCAN: begin
                    idx_q <= idx_q + AW'(1);
                    if (&idx_q) begin
                        state_q <= IDLE;
                    end
                end
            endcase
            if (evt) begin
                if (!pend_vld_q || take) begin
                    pend_vld_q   <= 1'b1;
                    pend_press_q <= ps2_key[9];
                    pend_code_q  <= ps2_key[8:0];
                end else if (drop_q != 8'hFF) begin
                    drop_q <= drop_q + 8'd1;
                end
            end else if (take) begin
                pend_vld_q <= 1'b0;
            end
        end
    end

    assign busy     = (state_q == SCAN);
    assign drop_cnt = drop_q;

    genvar gi, gj;
    generate
        for (gi = 0; gi < PLAYERS; gi++) begin : g_player
            logic [NB-1:0]      key_q;
            logic [NB-1:0]      raw;
            logic [NB-1:0]      out_d;
            logic [NB-1:0]      btn_q;
            logic [3:0]         dir;
            logic [BUTTONS-1:0] fire;
            logic               coin_prev_q;
            logic [15:0]        coin_cnt_q;
            logic               coin_out;
            logic               unused_joy;

            assign unused_joy = ^joy_in[16*gi+BUTTONS+5 +: 11-BUTTONS];
            // Joystick bits already sit in function order; it carries no coin.
            assign raw = key_q | {1'b0, joy_in[16*gi +: BUTTONS+5]};

            always_ff @(posedge clk_sys) begin
                if (!reset_n) begin
                    key_q <= '0;
                end else if (scan_hit && (ent[14:13] == 2'(gi))) begin
                    key_q[func_bit] <= cur_press_q;
                end
            end

            // dir and raw[3:0] are both {U,D,L,R}.
            always_comb begin
                dir = raw[3:0];
                case (rotate)
                    2'd1:    dir = {raw[1], raw[0], raw[2], raw[3]};
                    2'd2:    dir = {raw[0], raw[1], raw[3], raw[2]};
                    2'd3:    dir = {raw[2], raw[3], raw[0], raw[1]};
                    default: dir = raw[3:0];
                endcase
            end

            always_ff @(posedge clk_sys) begin
                if (!reset_n) begin
                    coin_prev_q <= 1'b0;
                    coin_cnt_q  <= '0;
                end else begin
                    coin_prev_q <= raw[NB-1];
                    if (raw[NB-1] && !coin_prev_q) begin
                        coin_cnt_q <= COIN_HOLD;
                    end else if (ce && (coin_cnt_q != 16'd0)) begin
                        coin_cnt_q <= coin_cnt_q - 16'd1;
                    end
                end
            end

            assign coin_out = raw[NB-1] | (coin_cnt_q != 16'd0);

            for (gj = 0; gj < BUTTONS; gj++) begin : g_fire
                logic [15:0] af_cnt_q;
                logic        af_low_q;
                logic        held;

                assign held = raw[4+gj];

                // Phase is held at "high" while released so each press starts with a high half.
                always_ff @(posedge clk_sys) begin
                    if (!reset_n || !held) begin
                        af_cnt_q <= '0;
                        af_low_q <= 1'b0;
                    end else if (ce) begin
                        if (af_cnt_q == AF_DIV - 16'd1) begin
                            af_cnt_q <= '0;
                            af_low_q <= ~af_low_q;
                        end else begin
                            af_cnt_q <= af_cnt_q + 16'd1;
                        end
                    end
                end

                assign fire[gj] = af_en[gi*BUTTONS+gj] ? (held & ~af_low_q) : held;
            end

            assign out_d = {coin_out, raw[BUTTONS+4], fire, dir};

            always_ff @(posedge clk_sys) begin
                if (!reset_n) begin
                    btn_q <= '0;
                end else begin
                    btn_q <= out_d;
                end
            end

            assign btn_out[gi*NB +: NB] = btn_q;
        end
    endgenerate

endmodule

// File: tb/tb_arcade_input_mapper.sv
// Directed bench for arcade_input_mapper: keymap scan timing, rotation, drops,
// coin stretch, autofire and reset behaviour.
module tb_arcade_input_mapper;
    localparam int PLAYERS   = 2;
    localparam int BUTTONS   = 4;
    localparam int MAP_DEPTH = 32;

    logic        clk_sys = 1'b0;
    logic        reset_n;
    logic        ce;
    logic [10:0] ps2_key;
    logic [31:0] joy_in;
    logic        map_wr;
    logic [4:0]  map_addr;
    logic [15:0] map_data;
    logic [1:0]  rotate;
    logic [7:0]  af_en;
    logic [19:0] btn_out;
    logic [7:0]  drop_cnt;
    logic        busy;

    int tests = 0;
    int fails = 0;

    always #5 clk_sys = ~clk_sys;

    arcade_input_mapper #(
        .PLAYERS  (PLAYERS),
        .BUTTONS  (BUTTONS),
        .MAP_DEPTH(MAP_DEPTH),
        .COIN_HOLD(16'd4),
        .AF_DIV   (16'd2)
    ) dut (
        .clk_sys (clk_sys),
        .reset_n (reset_n),
        .ce      (ce),
        .ps2_key (ps2_key),
        .joy_in  (joy_in),
        .map_wr  (map_wr),
        .map_addr(map_addr),
        .map_data(map_data),
        .rotate  (rotate),
        .af_en   (af_en),
        .btn_out (btn_out),
        .drop_cnt(drop_cnt),
        .busy    (busy)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk_sys);
    endtask

    task automatic map_write(input int addr, input logic [15:0] data);
        map_wr   = 1'b1;
        map_addr = 5'(addr);
        map_data = data;
        @(negedge clk_sys);
        map_wr   = 1'b0;
    endtask

    // Flips the strobe; the event is taken at the following rising edge.
    task automatic send_key(input logic pressed, input logic [8:0] code);
        ps2_key = {~ps2_key[10], pressed, code};
    endtask

    task automatic rot_step(input string tag, input logic [1:0] rot, input logic [31:0] joy,
                            input logic [19:0] exp);
        rotate = rot;
        joy_in = joy;
        cyc(2);
        check(tag, 32'(btn_out), 32'(exp));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        int       u_lat;
        int       s_lat;
        logic     busy_j0;
        logic     busy_j1;
        logic [9:0] pat;
        logic [4:0] pat5;
        int       coin_hi;
        logic     any_busy;

        reset_n  = 1'b0;
        ce       = 1'b1;
        ps2_key  = 11'd0;
        joy_in   = 32'd0;
        map_wr   = 1'b0;
        map_addr = 5'd0;
        map_data = 16'd0;
        rotate   = 2'd0;
        af_en    = 8'd0;
        cyc(3);
        check("reset_btn", 32'(btn_out), 32'h0);
        check("reset_drop", 32'(drop_cnt), 32'h0);
        check("reset_busy", 32'(busy), 32'h0);
        reset_n = 1'b1;
        cyc(1);

        for (int i = 0; i < MAP_DEPTH; i++) map_write(i, 16'h0000);
        map_write(0, 16'h8675);   // P0 U     <- 0x075
        map_write(1, 16'hA81C);   // P1 fire0 <- 0x01C
        map_write(2, 16'hEA1C);   // player 3: ignored
        map_write(3, 16'h001C);   // not valid: ignored
        map_write(4, 16'h9C1C);   // function 14: ignored
        map_write(5, 16'h9A26);   // P0 coin  <- 0x026
        map_write(31, 16'h9875);  // P0 start <- 0x075 (last entry)
        cyc(2);

        // Keymap press/release and scan timing
        u_lat = -1;
        s_lat = -1;
        busy_j0 = 1'b0;
        busy_j1 = 1'b0;
        send_key(1'b1, 9'h075);
        for (int j = 0; j < 40; j++) begin
            @(negedge clk_sys);
            if (j == 0) busy_j0 = busy;
            if (j == 1) busy_j1 = busy;
            if (btn_out[3] && u_lat < 0) u_lat = j;
            if (btn_out[8] && s_lat < 0) s_lat = j;
        end
        check("busy_edge0", 32'(busy_j0), 32'h0);
        check("busy_edge1", 32'(busy_j1), 32'h1);
        check("lat_entry0", 32'(u_lat), 32'd3);
        check("lat_entry31", 32'(s_lat), 32'd34);
        check("press_075", 32'(btn_out), 32'h00108);
        check("idle_after_scan", 32'(busy), 32'h0);
        send_key(1'b0, 9'h075);
        cyc(40);
        check("release_075", 32'(btn_out), 32'h0);
        send_key(1'b1, 9'h01C);
        cyc(40);
        check("press_01c", 32'(btn_out), 32'h04000);
        send_key(1'b0, 9'h01C);
        cyc(40);
        check("release_01c", 32'(btn_out), 32'h0);

        // Rotation and joystick merge
        rot_step("rot0_L", 2'd0, 32'h0000_0002, 20'h00002);
        rot_step("rot1_L", 2'd1, 32'h0000_0002, 20'h00008);
        rot_step("rot2_L", 2'd2, 32'h0000_0002, 20'h00004);
        rot_step("rot3_L", 2'd3, 32'h0000_0002, 20'h00001);
        rot_step("rot1_U", 2'd1, 32'h0000_0008, 20'h00001);
        rot_step("rot2_U", 2'd2, 32'h0000_0008, 20'h00002);
        rot_step("rot3_U", 2'd3, 32'h0000_0008, 20'h00004);
        rot_step("joy_no_coin", 2'd0, 32'h0000_0200, 20'h00000);
        rot_step("joy_p1_fire_start", 2'd0, 32'h0110_0000, 20'h44000);
        rot_step("joy_clear", 2'd0, 32'h0000_0000, 20'h00000);

        // Three toggles on consecutive cycles
        send_key(1'b1, 9'h01C);
        cyc(1);
        send_key(1'b0, 9'h01C);
        cyc(1);
        send_key(1'b1, 9'h01C);
        cyc(1);
        cyc(18);
        check("burst_first_applied", 32'(btn_out), 32'h04000);
        check("burst_busy", 32'(busy), 32'h1);
        cyc(25);
        check("burst_second_applied", 32'(btn_out), 32'h0);
        check("burst_drop1", 32'(drop_cnt), 32'd1);
        cyc(30);
        check("burst_idle", 32'(busy), 32'h0);
        check("burst_third_dropped", 32'(btn_out), 32'h0);
        for (int r = 0; r < 100; r++) begin
            send_key(1'b1, 9'h0AA);
            cyc(1);
            send_key(1'b0, 9'h0AA);
            cyc(1);
            send_key(1'b1, 9'h0AA);
            cyc(76);
        end
        check("drop_101", 32'(drop_cnt), 32'd101);
        for (int r = 0; r < 200; r++) begin
            send_key(1'b0, 9'h0AA);
            cyc(1);
            send_key(1'b1, 9'h0AA);
            cyc(1);
            send_key(1'b0, 9'h0AA);
            cyc(76);
        end
        check("drop_saturate", 32'(drop_cnt), 32'd255);

        // Coin stretcher, timer frozen while ce is low
        ce = 1'b0;
        send_key(1'b1, 9'h026);
        cyc(40);
        check("coin_raw", 32'(btn_out), 32'h00200);
        send_key(1'b0, 9'h026);
        cyc(40);
        check("coin_stretched", 32'(btn_out), 32'h00200);
        ce = 1'b1;
        cyc(2);
        ce = 1'b0;
        check("coin_at_count2", 32'(btn_out), 32'h00200);
        send_key(1'b1, 9'h026);
        cyc(40);
        send_key(1'b0, 9'h026);
        cyc(40);
        check("coin_reedge", 32'(btn_out), 32'h00200);
        ce = 1'b1;
        coin_hi = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk_sys);
            if (btn_out[9]) coin_hi++;
        end
        check("coin_hold_ticks", 32'(coin_hi), 32'd4);
        check("coin_expired", 32'(btn_out), 32'h0);

        // Autofire on P0 fire0
        af_en  = 8'h01;
        joy_in = 32'h0000_0010;
        pat    = '0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk_sys);
            pat = {pat[8:0], btn_out[4]};
        end
        check("af_pattern", 32'(pat), 32'(10'b1100110011));
        joy_in = 32'h0;
        cyc(1);
        check("af_release", 32'(btn_out[4]), 32'h0);
        af_en  = 8'h00;
        joy_in = 32'h0000_0010;
        pat5   = '0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk_sys);
            pat5 = {pat5[3:0], btn_out[4]};
        end
        check("af_disabled", 32'(pat5), 32'(5'b11111));
        joy_in = 32'h0;
        cyc(2);

        // Reset in the middle of a scan
        send_key(1'b1, 9'h075);
        cyc(10);
        check("mid_scan_u", 32'(btn_out), 32'h00008);
        check("mid_scan_busy", 32'(busy), 32'h1);
        reset_n = 1'b0;
        send_key(1'b0, 9'h075);
        cyc(1);
        check("rst_btn", 32'(btn_out), 32'h0);
        check("rst_busy", 32'(busy), 32'h0);
        check("rst_drop", 32'(drop_cnt), 32'h0);
        cyc(1);
        reset_n  = 1'b1;
        any_busy = 1'b0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk_sys);
            any_busy = any_busy | busy;
        end
        check("rst_no_event", 32'(any_busy), 32'h0);
        check("rst_btn_quiet", 32'(btn_out), 32'h0);
        send_key(1'b1, 9'h075);
        cyc(40);
        check("map_kept", 32'(btn_out), 32'h00108);
        send_key(1'b0, 9'h075);
        cyc(40);
        check("map_kept_release", 32'(btn_out), 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
